// File: rtl/sync_fifo_ctrl_if.sv
// Valid/ready write and show-ahead read handshakes between the FIFO controller
// and the surrounding producer/consumer logic.
interface sync_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 39
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;

  // Master is the producer/consumer side, slave is the controller.
  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Pointer, flag and handshake controller for a synchronous FIFO built around a
// dual-port RAM with registered read data, plus a one-entry show-ahead output stage.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 39,
  parameter int ADDR_WIDTH = 14,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 4
) (
  input  logic                  clk,
  input  logic                  reset,
  sync_fifo_ctrl_if.slave       bus,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_wr_ptr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_rd_ptr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  ram_full,
  output logic                  ram_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] PtrOne = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH:0] wptr;
  logic [ADDR_WIDTH:0] rptr;
  logic [ADDR_WIDTH:0] ram_count;
  logic                rd_valid_q;
  logic                overflow_q;

  // The extra MSB on each pointer separates "full" from "empty" when the low bits match.
  assign ram_empty = (wptr == rptr);
  assign ram_full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                     (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);

  assign ram_wr_ptr = wptr[ADDR_WIDTH-1:0];
  assign ram_rd_ptr = rptr[ADDR_WIDTH-1:0];
  assign ram_din    = bus.wr_data;

  assign bus.wr_ready = !ram_full && !reset;
  assign ram_we       = bus.wr_valid && bus.wr_ready;

  // Refill the output stage whenever it is empty or being drained this cycle.
  assign ram_re       = !ram_empty && (!rd_valid_q || bus.rd_ready) && !reset;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = ram_dout;

  assign ram_count   = wptr - rptr;
  assign level       = ram_count + {{ADDR_WIDTH{1'b0}}, rd_valid_q};
  assign almost_full = 32'(level) >= 32'(AF_LEVEL);
  assign overflow    = overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (ram_we) begin
        wptr <= wptr + PtrOne;
      end
      if (ram_re) begin
        rptr <= rptr + PtrOne;
      end
      if (ram_re) begin
        rd_valid_q <= 1'b1;
      end else if (bus.rd_ready) begin
        rd_valid_q <= 1'b0;
      end
      if (bus.wr_valid && !bus.wr_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl with a behavioural RAM, an occupancy model
// and a data scoreboard.
module tb_sync_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int AF = 3;
  localparam int RAM_DEPTH = 2**AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          ram_we;
  logic [AW-1:0] ram_wr_ptr;
  logic [DW-1:0] ram_din;
  logic          ram_re;
  logic [AW-1:0] ram_rd_ptr;
  logic [DW-1:0] ram_dout;
  logic          ram_full;
  logic          ram_empty;
  logic [AW:0]   level;
  logic          almost_full;
  logic          overflow;

  sync_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  sync_fifo_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_LEVEL  (AF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .ram_we     (ram_we),
    .ram_wr_ptr (ram_wr_ptr),
    .ram_din    (ram_din),
    .ram_re     (ram_re),
    .ram_rd_ptr (ram_rd_ptr),
    .ram_dout   (ram_dout),
    .ram_full   (ram_full),
    .ram_empty  (ram_empty),
    .level      (level),
    .almost_full(almost_full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Dual-port RAM with registered read data that only updates on a read enable.
  logic [DW-1:0] mem [RAM_DEPTH];
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_wr_ptr] <= ram_din;
    if (ram_re) ram_dout <= mem[ram_rd_ptr];
  end

  int            vectors = 0;
  int            miscompares = 0;
  int            ram_cnt = 0;
  logic          out_valid = 1'b0;
  logic          ovf_model = 1'b0;
  logic [DW-1:0] exp_q [$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance model and clock.
  task automatic applyStimulus(input logic rst, input logic wv, input logic [DW-1:0] wd, input logic rr);
    logic          exp_ready;
    logic          exp_re;
    logic          accept;
    int            lvl;
    logic [DW-1:0] head;
    reset        = rst;
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_ready = rr;
    #1;
    exp_ready = !rst && (ram_cnt < RAM_DEPTH);
    exp_re    = !rst && (ram_cnt > 0) && (!out_valid || rr);
    accept    = wv && exp_ready;
    lvl       = ram_cnt + int'(out_valid);
    checkOutput("wr_ready",    32'(bus.wr_ready), 32'(exp_ready));
    checkOutput("ram_we",      32'(ram_we),       32'(accept));
    checkOutput("ram_re",      32'(ram_re),       32'(exp_re));
    checkOutput("rd_valid",    32'(bus.rd_valid), 32'(out_valid));
    checkOutput("level",       32'(level),        32'(lvl));
    checkOutput("almost_full", 32'(almost_full),  32'(lvl >= AF));
    checkOutput("ram_empty",   32'(ram_empty),    32'(ram_cnt == 0));
    checkOutput("ram_full",    32'(ram_full),     32'(ram_cnt == RAM_DEPTH));
    checkOutput("overflow",    32'(overflow),     32'(ovf_model));
    if (!rst && out_valid && rr) begin
      checkOutput("sb_nonempty", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) begin
        head = exp_q.pop_front();
        checkOutput("rd_data", 32'(bus.rd_data), 32'(head));
      end
    end
    if (rst) begin
      ram_cnt   = 0;
      out_valid = 1'b0;
      ovf_model = 1'b0;
      exp_q.delete();
    end else begin
      if (accept) exp_q.push_back(wd);
      if (wv && !exp_ready) ovf_model = 1'b1;
      ram_cnt = ram_cnt + int'(accept) - int'(exp_re);
      if (exp_re) out_valid = 1'b1;
      else if (rr) out_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] reset state");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    $display("[TB] single word 0xA1, two-cycle latency");
    applyStimulus(1'b0, 1'b1, 8'hA1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("a1_valid", 32'(bus.rd_valid), 32'(1));
    checkOutput("a1_data",  32'(bus.rd_data),  32'(8'hA1));
    checkOutput("a1_level", 32'(level),        32'(1));
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    $display("[TB] fill with 1..6, consumer stalled");
    for (int i = 1; i <= 6; i++) applyStimulus(1'b0, 1'b1, 8'(i), 1'b0);
    checkOutput("fill_level",    32'(level),        32'(5));
    checkOutput("fill_af",       32'(almost_full),  32'(1));
    checkOutput("fill_overflow", 32'(overflow),     32'(1));
    checkOutput("fill_wr_ready", 32'(bus.wr_ready), 32'(0));

    $display("[TB] stall three cycles, head word must hold");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput("stall_data", 32'(bus.rd_data), 32'(8'h01));
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("drain_empty", 32'(ram_empty), 32'(1));
    checkOutput("drain_level", 32'(level),     32'(0));

    $display("[TB] streaming 0..19");
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 8'(i), 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("stream_drained", 32'(exp_q.size()), 32'(0));

    $display("[TB] reset with words held");
    applyStimulus(1'b0, 1'b1, 8'h31, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h32, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h33, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("pre_rst_valid", 32'(bus.rd_valid), 32'(1));
    checkOutput("pre_rst_level", 32'(level),        32'(3));
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("rst_valid",    32'(bus.rd_valid), 32'(0));
    checkOutput("rst_level",    32'(level),        32'(0));
    checkOutput("rst_overflow", 32'(overflow),     32'(0));
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("post_rst_data", 32'(bus.rd_data), 32'(8'h55));
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Pointer, flag and handshake controller for the synchronous FIFO. It drives the FIFO's dual-port storage RAM on both ports and presents valid/ready write and read interfaces to the surrounding design. The read side is show-ahead: the word at the head of the FIFO is already on `rd_data` whenever `rd_valid` is high. It sits between producer/consumer logic and the RAM instance inside the `sync_fifo` top level.

## Interface
- `DATA_WIDTH`, default 39: word width, matching the RAM.
- `ADDR_WIDTH`, default 14: RAM address width; RAM depth is `2**ADDR_WIDTH`.
- `AF_LEVEL`, default `2**ADDR_WIDTH - 4`: `almost_full` threshold, compared against `level`.
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1: common clock for the controller and the RAM.
- `reset`  in  1: synchronous, active-high reset.
- `wr_valid`  in  1: producer offers `wr_data`.
- `wr_ready`  out  1: controller accepts a word this cycle.
- `wr_data`  in  DATA_WIDTH: write word.
- `rd_valid`  out  1: `rd_data` holds the head word.
- `rd_ready`  in  1: consumer takes the head word.
- `rd_data`  out  DATA_WIDTH: head word, wired directly from `ram_dout`.
- `ram_we`  out  1: RAM write enable.
- `ram_wr_ptr`  out  ADDR_WIDTH: RAM write address.
- `ram_din`  out  DATA_WIDTH: RAM write data (equals `wr_data`).
- `ram_re`  out  1: RAM read enable.
- `ram_rd_ptr`  out  ADDR_WIDTH: RAM read address.
- `ram_dout`  in  DATA_WIDTH: RAM registered read data, updated only on `ram_re`.
- `ram_full`  out  1: RAM-full flag, driven to the RAM.
- `ram_empty`  out  1: RAM-empty flag, driven to the RAM.
- `level`  out  ADDR_WIDTH+1: total words held (RAM plus output stage).
- `almost_full`  out  1: high when `level >= AF_LEVEL`.
- `overflow`  out  1: sticky; set when `wr_valid` is high while `wr_ready` is low.

## Operation
- Pointers:
  - `wptr` and `rptr` are ADDR_WIDTH+1-bit registers; the MSB is the wrap bit.
  - `ram_wr_ptr = wptr[ADDR_WIDTH-1:0]` and `ram_rd_ptr = rptr[ADDR_WIDTH-1:0]`.
  - Both pointers increment modulo `2**(ADDR_WIDTH+1)`.
- Flags, combinational from the registered pointers:
  - `ram_empty = (wptr == rptr)`.
  - `ram_full = (wptr[MSB] != rptr[MSB]) && (low bits equal)`.
- Write side:
  - `wr_ready = !ram_full && !reset`.
  - `ram_we = wr_valid && wr_ready`.
  - `wptr` increments on every cycle in which `ram_we` is high.
- Read side (one-entry output stage; `rd_data` is `ram_dout` itself):
  - `ram_re = !ram_empty && (!rd_valid || rd_ready) && !reset`.
  - `rptr` increments whenever `ram_re` is high.
  - Next `rd_valid`: 1 if `ram_re`; otherwise 0 if `rd_ready`; otherwise hold.
- Occupancy:
  - `level = (wptr - rptr)` (modulo, zero-extended) `+ rd_valid`.
  - Maximum `level` is `2**ADDR_WIDTH + 1`.
- Simultaneous events:
  - A write and a read in the same cycle are independent.
  - A RAM read never targets the slot being written in that cycle, because empty is evaluated from registered pointers.
- Full condition:
  - The FIFO can hold `2**ADDR_WIDTH + 1` words (RAM full plus output stage valid).
  - A pop while the RAM is full frees one RAM slot in the following cycle, not the same cycle.
- `overflow` is set on any `wr_valid && !wr_ready` outside reset and is cleared only by `reset`.

## Timing
- Reset, synchronous:
  - On the first rising edge with `reset` high: `wptr = rptr = 0`, `rd_valid = 0`, `overflow = 0`.
  - While `reset` is high, `ram_we`, `ram_re` and `wr_ready` are forced to 0.
  - After reset: `ram_empty = 1`, `ram_full = 0`, `level = 0`, `almost_full = 0` (for `AF_LEVEL > 0`).
  - Reset mid-operation discards all contents, including a valid output word. The next word read after reset is the first word written after reset.
- Write accepted at edge N: `ram_empty` falls after N, `ram_re` is issued in cycle N+1, and `rd_valid` is high after edge N+1. Write-to-read latency is 2 cycles.
- Steady state: one write and one read per cycle sustained indefinitely with no bubbles.
- `rd_data` is stable while `rd_valid && !rd_ready`, because no `ram_re` is issued in that case.
- `level` and `almost_full` are combinational from registers and have no input-to-output paths.

## Test plan
- Bench parameters for all scenarios: `ADDR_WIDTH = 2`, `AF_LEVEL = 3`.
- Reset, then push 0xA1: `wr_ready = 1`; `rd_valid` rises 2 cycles after acceptance with `rd_data = 0xA1`; `level` goes 0 → 1.
- Push 1..6 with `rd_ready = 0`:
  - Five words are accepted (4 in RAM plus 1 in the output stage), then `wr_ready = 0`.
  - `level = 5`, `almost_full = 1`, and `overflow = 1` after the 6th attempt.
- Continuous push and pop of 0..19 with `rd_ready = 1`:
  - Output order is 0..19 with no gaps after the initial latency.
  - Pointers wrap twice; `ram_full` is never asserted.
- Fill the FIFO, then stall: hold `rd_ready` low for 3 cycles and check `rd_data` is unchanged. Then pop everything: data order is preserved, `ram_empty = 1`, and `level = 0` at the end.
- Assert `reset` for one cycle while 3 words are held and `rd_valid = 1`:
  - The next cycle shows `rd_valid = 0`, `level = 0`, `overflow = 0`.
  - Push 0x55: it is the next word read out.
